// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC select and fetch stall/flush control; define PC_SEQ_TRAP_EN to add trap entry/return, TRAP_DRAIN and epc.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0180,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] curPC,
  input  logic        if_ready,
  input  logic        id_load_use,
  input  logic        md_busy,
  input  logic        id_jump,
  input  logic [31:0] id_jump_target,
  input  logic        ex_branch_taken,
  input  logic [31:0] ex_branch_target,
  input  logic        exc_req,
  input  logic [31:0] exc_pc,
  input  logic        eret,
  output logic [31:0] PCOut,
  output logic        stall,
  output logic        flush,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic [31:0] epc,
  output logic [1:0]  state
);
  typedef enum logic [1:0] {RUN = 2'd0, REDIR_PEND = 2'd1, TRAP_DRAIN = 2'd2} state_t;
  state_t st, nxt;
  logic [31:0] pend_pc, nxt_pend, redir_pc;
  logic [3:0] drain_cnt, nxt_drain;
  logic exc, ert, redir, redir_idex;
`ifdef PC_SEQ_TRAP_EN
  assign exc = exc_req;
  assign ert = eret;
  always_ff @(posedge CLK or negedge Reset)
    if (!Reset) epc <= '0;
    else if (st != TRAP_DRAIN && exc_req) epc <= exc_pc;
`else
  logic unused_trap;
  assign unused_trap = ^{exc_req, eret, exc_pc};
  assign exc = 1'b0;
  assign ert = 1'b0;
  assign epc = '0;
`endif
  assign state = st;
  assign redir = ert | ex_branch_taken | id_jump;
  assign redir_pc = ert ? epc : ex_branch_taken ? ex_branch_target : id_jump_target;
  assign redir_idex = !ert && ex_branch_taken;
  always_comb begin
    PCOut = curPC + 32'd4;
    stall = 1'b0;
    flush = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    nxt = st;
    nxt_pend = pend_pc;
    nxt_drain = drain_cnt;
    if (!Reset) begin
      PCOut = RESET_PC;
      stall = 1'b1;
    end else if (st == TRAP_DRAIN) begin
      PCOut = curPC;
      stall = 1'b1;
      nxt_drain = drain_cnt - 4'd1;
      nxt = drain_cnt <= 4'd1 ? RUN : TRAP_DRAIN;
    end else if (exc) begin
      PCOut = TRAP_VECTOR;
      flush = 1'b1;
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
      nxt_drain = 4'(DRAIN_CYCLES);
      nxt = DRAIN_CYCLES == 0 ? RUN : TRAP_DRAIN;
    end else if (st == REDIR_PEND) begin
      PCOut = pend_pc;
      stall = !if_ready;
      flush = if_ready;
      nxt = if_ready ? RUN : REDIR_PEND;
    end else if (redir) begin
      // An unready memory turns the redirect into a buffered one retried from REDIR_PEND.
      PCOut = redir_pc;
      stall = !if_ready;
      flush = if_ready;
      flush_ifid = 1'b1;
      flush_idex = redir_idex;
      nxt_pend = if_ready ? pend_pc : redir_pc;
      nxt = if_ready ? RUN : REDIR_PEND;
    end else if (id_load_use) begin
      stall = 1'b1;
      flush_idex = 1'b1;
    end else if (md_busy || !if_ready) begin
      stall = 1'b1;
    end
  end
  always_ff @(posedge CLK or negedge Reset)
    if (!Reset) begin
      st <= RUN;
      pend_pc <= '0;
      drain_cnt <= '0;
    end else begin
      st <= nxt;
      pend_pc <= nxt_pend;
      drain_cnt <= nxt_drain;
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed test-plan cases plus randomized traffic against a rule-level reference model.
module tb_pc_sequencer;
  localparam logic [31:0] TV = 32'h0000_0180;
  localparam int DC = 2;
`ifdef PC_SEQ_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif
  logic CLK = 1'b0, Reset = 1'b1;
  logic [31:0] curPC = '0, id_jump_target = '0, ex_branch_target = '0, exc_pc = '0;
  logic if_ready = 1'b1, id_load_use = 1'b0, md_busy = 1'b0, id_jump = 1'b0;
  logic ex_branch_taken = 1'b0, exc_req = 1'b0, eret = 1'b0;
  logic [31:0] PCOut, epc;
  logic stall, flush, flush_ifid, flush_idex;
  logic [1:0] state;
  int checks = 0, failures = 0;
  int m_mode = 0, m_left = 0;
  logic [31:0] m_pend = '0, m_epc = '0, m_pc = '0;
  always #5 CLK = ~CLK;
  pc_sequencer #(.RESET_PC(32'h0), .TRAP_VECTOR(TV), .DRAIN_CYCLES(DC)) dut (
    .CLK(CLK), .Reset(Reset), .curPC(curPC), .if_ready(if_ready), .id_load_use(id_load_use),
    .md_busy(md_busy), .id_jump(id_jump), .id_jump_target(id_jump_target),
    .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target), .exc_req(exc_req),
    .exc_pc(exc_pc), .eret(eret), .PCOut(PCOut), .stall(stall), .flush(flush),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex), .epc(epc), .state(state)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic idle();
    if_ready = 1'b1; id_load_use = 1'b0; md_busy = 1'b0; id_jump = 1'b0;
    ex_branch_taken = 1'b0; exc_req = 1'b0; eret = 1'b0;
  endtask
  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask
  task automatic ctl(input string tag, input logic s, input logic f, input logic fi, input logic fe);
    check({tag, "_stall"}, stall, s);
    check({tag, "_flush"}, flush, f);
    check({tag, "_fifid"}, flush_ifid, fi);
    check({tag, "_fidex"}, flush_idex, fe);
  endtask
  task automatic model_cycle();
    int rule, n_mode, n_left;
    logic [31:0] e_pc, tgt, n_pend, n_epc;
    logic e_st, e_fl, e_fi, e_fe, def;
    e_pc = curPC + 32'd4; e_st = 0; e_fl = 0; e_fi = 0; e_fe = 0; def = 1;
    n_mode = m_mode; n_left = m_left; n_pend = m_pend; n_epc = m_epc;
    rule = !Reset ? -1 : m_mode == 2 ? 0 : (TRAP_EN && exc_req) ? 1 : m_mode == 1 ? 8 :
           (TRAP_EN && eret) ? 2 : ex_branch_taken ? 3 : id_jump ? 4 : id_load_use ? 5 :
           (md_busy || !if_ready) ? 6 : 7;
    tgt = rule == 2 ? m_epc : rule == 3 ? ex_branch_target : id_jump_target;
    case (rule)
      -1: begin e_pc = 32'h0; e_st = 1; end
      0: begin e_pc = curPC; e_st = 1; n_left = m_left - 1; n_mode = m_left == 1 ? 0 : 2; end
      1: begin e_pc = TV; e_fl = 1; e_fi = 1; e_fe = 1; n_epc = exc_pc; n_left = DC; n_mode = DC > 0 ? 2 : 0; end
      8: begin e_pc = m_pend; e_fl = if_ready; e_st = !if_ready; n_mode = if_ready ? 0 : 1; end
      2, 3, 4: begin
        e_fi = 1; e_fe = rule == 3;
        if (if_ready) begin e_pc = tgt; e_fl = 1; end
        else begin e_st = 1; def = 0; n_pend = tgt; n_mode = 1; end
      end
      5: begin e_st = 1; e_fe = 1; def = 0; end
      6: begin e_st = 1; def = 0; end
      default: ;
    endcase
    check("r_state", state, 32'(m_mode));
    check("r_epc", epc, m_epc);
    ctl("r", e_st, e_fl, e_fi, e_fe);
    if (def) check("r_pcout", PCOut, e_pc);
    m_pc = !Reset ? 32'h0 : (e_fl || !e_st) ? e_pc : m_pc;
    m_mode = n_mode; m_left = n_left; m_pend = n_pend; m_epc = n_epc;
  endtask
  initial begin
    idle();
    curPC = 32'h100;
    #1 Reset = 1'b0;
    #10;
    check("rst_pcout", PCOut, 32'h0);
    check("rst_state", state, 32'h0);
    ctl("rst", 1, 0, 0, 0);
    next_cycle();
    Reset = 1'b1;
    @(negedge CLK);
    check("seq_pcout", PCOut, 32'h104);
    ctl("seq", 0, 0, 0, 0);
    curPC = 32'hFFFF_FFFC;
    #1 check("wrap_pcout", PCOut, 32'h0);
    next_cycle();
    curPC = 32'h300; ex_branch_taken = 1; ex_branch_target = 32'h400;
    id_jump = 1; id_jump_target = 32'h800;
    @(negedge CLK);
    check("bj_pcout", PCOut, 32'h400);
    ctl("bj", 0, 1, 1, 1);
    next_cycle();
    idle();
    curPC = 32'h400; id_jump = 1; id_jump_target = 32'h200; if_ready = 0;
    @(negedge CLK);
    ctl("jnr", 1, 0, 1, 0);
    next_cycle();
    id_jump = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("pend_state", state, 32'h1);
      check("pend_stall", stall, 1'b1);
      check("pend_pcout", PCOut, 32'h200);
      next_cycle();
    end
    if_ready = 1;
    @(negedge CLK);
    check("pend_flush", flush, 1'b1);
    check("pend_go_pc", PCOut, 32'h200);
    next_cycle();
    curPC = 32'h200;
    @(negedge CLK);
    check("pend_done", state, 32'h0);
    check("pend_seq", PCOut, 32'h204);
    id_load_use = 1;
    next_cycle();
    @(negedge CLK);
    ctl("lu", 1, 0, 0, 1);
    next_cycle();
    id_load_use = 0;
    @(negedge CLK);
    ctl("lu_end", 0, 0, 0, 0);
    next_cycle();
    md_busy = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      ctl("md", 1, 0, 0, 0);
      next_cycle();
    end
    md_busy = 0;
    @(negedge CLK);
    ctl("md_end", 0, 0, 0, 0);
    next_cycle();
    curPC = 32'h500; exc_req = 1; exc_pc = 32'h330;
    @(negedge CLK);
    check("trap_pc", PCOut, TRAP_EN ? TV : 32'h504);
    check("trap_flush", flush, TRAP_EN);
    next_cycle();
    exc_req = 0;
    curPC = TRAP_EN ? TV : 32'h504;
    for (int i = 0; i < DC; i++) begin
      @(negedge CLK);
      check("drain_epc", epc, TRAP_EN ? 32'h330 : 32'h0);
      check("drain_stall", stall, TRAP_EN);
      check("drain_state", state, TRAP_EN ? 32'h2 : 32'h0);
      next_cycle();
    end
    @(negedge CLK);
    check("drain_done", state, 32'h0);
    check("drain_stall0", stall, 1'b0);
    next_cycle();
    eret = 1;
    @(negedge CLK);
    check("eret_pc", PCOut, TRAP_EN ? 32'h330 : curPC + 32'd4);
    check("eret_flush", flush, TRAP_EN);
    next_cycle();
    idle();
    id_jump = 1; id_jump_target = 32'h700; if_ready = 0;
    next_cycle();
    idle();
    if_ready = 0;
    #1 check("ar_pre", state, 32'h1);
    Reset = 0;
    #1;
    check("ar_state", state, 32'h0);
    check("ar_pcout", PCOut, 32'h0);
    next_cycle();
    if_ready = 1; curPC = 32'h600; Reset = 1;
    @(negedge CLK);
    check("ar_seq", PCOut, 32'h604);
    check("ar_stall", stall, 1'b0);
    next_cycle();
    Reset = 0;
    m_mode = 0; m_left = 0; m_pend = '0; m_epc = '0; m_pc = '0;
    next_cycle();
    for (int n = 0; n < 3000; n++) begin
      Reset = $urandom_range(0, 199) != 0;
      if_ready = $urandom_range(0, 3) != 0;
      id_load_use = $urandom_range(0, 7) == 0;
      md_busy = $urandom_range(0, 7) == 0;
      id_jump = $urandom_range(0, 7) == 0;
      ex_branch_taken = $urandom_range(0, 9) == 0;
      exc_req = $urandom_range(0, 19) == 0;
      eret = $urandom_range(0, 14) == 0;
      id_jump_target = $urandom & ~32'h3;
      ex_branch_target = $urandom & ~32'h3;
      exc_pc = $urandom & ~32'h3;
      if ($urandom_range(0, 31) == 0) m_pc = 32'hFFFF_FFFC;
      curPC = m_pc;
      if (!Reset) begin m_mode = 0; m_left = 0; m_pend = '0; m_epc = '0; end
      @(negedge CLK);
      model_cycle();
      next_cycle();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
